// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: the instruction-memory port plus the decode handshake.
// No latency of its own; it only carries wires between fetch, memory and decode.
// Backpressure travels on inst_ready, from decode (slave) to fetch (master).
//
// Signals:
//   mem_addr   fetch -> memory  word address (equals the fetch PC)
//   mem_inst   memory -> fetch  instruction at mem_addr, same cycle
//   inst_valid fetch -> decode  buffer head is valid
//   inst_ready decode -> fetch  decode accepts the head this cycle
//   inst       fetch -> decode  head instruction
//   inst_pc    fetch -> decode  PC of the head instruction
interface fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int INST_W = 13
);
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_inst;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output mem_addr, inst_valid, inst, inst_pc,
        input  mem_inst, inst_ready
    );

    modport slave (
        input  mem_addr, inst_valid, inst, inst_pc,
        output mem_inst, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational memory, buffers {inst, pc} in 2 entries.
// Latency: start at edge N -> first push at N+1 -> inst_valid the cycle after; then 1 inst/cycle.
// Backpressure: when both entries are full and decode does not pop, the PC holds and is re-presented.
//
// Ports: clk, rst (synchronous, active high), start, redirect_valid/redirect_pc,
//        halted (high in HALTED), bus (fetch_unit_if.master: memory + decode handshake),
//        fetch_count (only when FETCH_PERF_CNT_EN is defined: saturating 8-bit pop counter).
// Optional feature macro: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int                ADDR_W      = 5,
    parameter int                INST_W      = 13,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [INST_W-1:0] HALT_OPCODE = '0,
    parameter int                BUF_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    fetch_unit_if.master      bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [7:0]        fetch_count
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    entry_t            ent0_q, ent0_d;   // head
    entry_t            ent1_q, ent1_d;   // second entry
    logic              halted_q;
    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  tail;

    assign pop = (cnt_q != '0) && bus.inst_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        push    = 1'b0;
        tail    = cnt_q - CNT_W'(pop);

        if (redirect_valid) begin
            // Redirect wins over start, push and halt; a same-cycle pop is still
            // accepted by decode, the flush simply discards whatever remains.
            state_d = RUN;
            pc_d    = redirect_pc;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     push = (cnt_q != FULL) || pop;
                default: ;
            endcase

            if (push) begin
                // The halt word itself is buffered; the PC parks on its address.
                if (bus.mem_inst == HALT_OPCODE) state_d = HALTED;
                else                             pc_d    = pc_q + ADDR_W'(1);
            end

            // Shift only when a second entry exists, so the head output keeps
            // its last value once the buffer runs empty.
            if (pop && cnt_q == FULL) ent0_d = ent1_q;

            if (push) begin
                if (tail == '0) ent0_d = '{inst: bus.mem_inst, pc: pc_q};
                else            ent1_d = '{inst: bus.mem_inst, pc: pc_q};
            end

            cnt_d = cnt_q - CNT_W'(pop) + CNT_W'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            ent0_q   <= '0;
            ent1_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            halted_q <= (state_d == HALTED);
        end
    end

    assign bus.mem_addr   = pc_q;
    assign bus.inst_valid = (cnt_q != '0);
    assign bus.inst       = ent0_q.inst;
    assign bus.inst_pc    = ent0_q.pc;
    assign halted         = halted_q;

`ifdef FETCH_PERF_CNT_EN
    // Counts accepted instructions; only reset clears it, redirect does not.
    always_ff @(posedge clk) begin
        if (rst)                             fetch_count <= '0;
        else if (pop && fetch_count != 8'hFF) fetch_count <= fetch_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: table of per-cycle stimulus with expected outputs,
// followed by hand-written halt-drain and (optionally) counter-saturation sequences.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic       redirect_valid;
    logic [4:0] redirect_pc;
    logic       halted;
`ifdef FETCH_PERF_CNT_EN
    logic [7:0] fetch_count;
`endif

    logic [12:0] mem [32];

    fetch_unit_if #(.ADDR_W(5), .INST_W(13)) bus ();

    assign bus.mem_inst = mem[bus.mem_addr];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .bus            (bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        rv;
        logic [4:0]  rpc;
        logic        rdy;
        logic        ev;      // expected inst_valid
        logic        cd;      // check inst/inst_pc this cycle
        logic [12:0] ei;
        logic [4:0]  ep;
        logic        eh;
        logic [4:0]  ea;
        int          ecnt;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic r, logic s, logic rv, logic [4:0] rpc, logic rdy,
                                logic ev, logic cd, logic [12:0] ei, logic [4:0] ep,
                                logic eh, logic [4:0] ea, int ecnt);
        vec_t v;
        v.rst = r; v.start = s; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.cd = cd; v.ei = ei; v.ep = ep; v.eh = eh; v.ea = ea; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic r, logic s, logic rv, logic [4:0] rpc, logic rdy);
        rst = r; start = s; redirect_valid = rv; redirect_pc = rpc; bus.inst_ready = rdy;
    endtask

    task automatic chk_out(string tag, logic ev, logic cd, logic [12:0] ei, logic [4:0] ep,
                           logic eh, logic [4:0] ea);
        chk({tag, " inst_valid"}, 32'(bus.inst_valid), 32'(ev));
        chk({tag, " halted"},     32'(halted),         32'(eh));
        chk({tag, " mem_addr"},   32'(bus.mem_addr),   32'(ea));
        if (cd) begin
            chk({tag, " inst"},    32'(bus.inst),    32'(ei));
            chk({tag, " inst_pc"}, 32'(bus.inst_pc), 32'(ep));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 13'h1000 | 13'(i);
        mem[0] = 13'h1FFF;
        mem[1] = 13'h04CA;
        mem[2] = 13'h0003;
        mem[3] = 13'h0000;

        //            rst st rv rpc rdy  ev cd ei       ep  eh ea  cnt
        // Scenario 1: reset, start, stream to halt
        vecs.push_back(mk(1, 0, 0, 0,  1,  0, 1, 13'h0000, 0,  0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0,  1,  0, 0, 13'h0000, 0,  0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h1FFF, 0,  0, 1,  0));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h04CA, 1,  0, 2,  1));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h0003, 2,  0, 3,  2));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h0000, 3,  1, 3,  3));
        vecs.push_back(mk(0, 0, 0, 0,  1,  0, 0, 13'h0000, 0,  1, 3,  4));
        vecs.push_back(mk(0, 1, 0, 0,  1,  0, 0, 13'h0000, 0,  1, 3,  4));
        // Scenario 2: backpressure for 5 cycles after start
        vecs.push_back(mk(1, 0, 0, 0,  1,  0, 1, 13'h0000, 0,  0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0,  0,  0, 0, 13'h0000, 0,  0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1, 1, 13'h1FFF, 0,  0, 1,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1, 1, 13'h1FFF, 0,  0, 2,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1, 1, 13'h1FFF, 0,  0, 2,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1, 1, 13'h1FFF, 0,  0, 2,  0));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1, 1, 13'h1FFF, 0,  0, 2,  0));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h04CA, 1,  0, 3,  1));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h0003, 2,  1, 3,  2));
        // Scenario 3: redirect to 20 with 2 buffered while halted; start in RUN ignored
        vecs.push_back(mk(0, 0, 1, 20, 0,  0, 0, 13'h0000, 0,  0, 20, 2));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h1014, 20, 0, 21, 2));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h1015, 21, 0, 22, 3));
        vecs.push_back(mk(0, 1, 0, 0,  1,  1, 1, 13'h1016, 22, 0, 23, 4));
        // Scenario 4: wrap 30, 31, 0 (redirect-cycle pop counts)
        vecs.push_back(mk(0, 0, 1, 30, 1,  0, 0, 13'h0000, 0,  0, 30, 5));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h101E, 30, 0, 31, 5));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h101F, 31, 0, 0,  6));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h1FFF, 0,  0, 1,  7));
        vecs.push_back(mk(0, 0, 0, 0,  0,  1, 1, 13'h1FFF, 0,  0, 2,  7));
        // Scenario 5: reset mid-stream (rst overrides start), then idle until start
        vecs.push_back(mk(1, 1, 0, 0,  1,  0, 1, 13'h0000, 0,  0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  1,  0, 0, 13'h0000, 0,  0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  1,  0, 0, 13'h0000, 0,  0, 0,  0));
        // Redirect and start together in IDLE: redirect target wins
        vecs.push_back(mk(0, 1, 1, 5,  1,  0, 0, 13'h0000, 0,  0, 5,  0));
        vecs.push_back(mk(0, 0, 0, 0,  1,  1, 1, 13'h1005, 5,  0, 6,  0));

        drive(1, 0, 0, 0, 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].rst, vecs[i].start, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            cyc();
            chk_out(tag, vecs[i].ev, vecs[i].cd, vecs[i].ei, vecs[i].ep, vecs[i].eh, vecs[i].ea);
`ifdef FETCH_PERF_CNT_EN
            chk({tag, " fetch_count"}, 32'(fetch_count), 32'(vecs[i].ecnt));
`endif
        end

        // Halt reached with both entries held: buffered words still drain.
        drive(0, 0, 1, 2, 0); cyc();
        chk_out("drain0", 0, 0, 13'h0000, 0, 0, 2);
        drive(0, 0, 0, 0, 0); cyc();
        chk_out("drain1", 1, 1, 13'h0003, 2, 0, 3);
        cyc();
        chk_out("drain2", 1, 1, 13'h0003, 2, 1, 3);
        cyc();
        chk_out("drain3", 1, 1, 13'h0003, 2, 1, 3);
        drive(0, 0, 0, 0, 1); cyc();
        chk_out("drain4", 1, 1, 13'h0000, 3, 1, 3);
        cyc();
        chk_out("drain5", 0, 0, 13'h0000, 0, 1, 3);

`ifdef FETCH_PERF_CNT_EN
        // Saturation: no halt word in memory, stream 300 words.
        mem[3] = 13'h1003;
        drive(1, 0, 0, 0, 1); cyc();
        chk("sat reset fetch_count", 32'(fetch_count), 32'd0);
        drive(0, 1, 0, 0, 1); cyc();
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 300; k++) cyc();
        chk("sat fetch_count", 32'(fetch_count), 32'd255);
        drive(0, 0, 1, 7, 1); cyc();
        drive(0, 0, 0, 0, 1); cyc();
        chk("sat after redirect fetch_count", 32'(fetch_count), 32'd255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
